// File: rtl/up_count_checker.sv
// up_count_checker: monitors a free-running WIDTH-bit up counter sampled in
// the same clock domain. It confirms the value advances by exactly +1 every
// cycle, and reports lock status, sequence faults and wrap events.
module up_count_checker #(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 2,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  count_in,
  input  logic              enable,
  input  logic              err_clr,
  output logic              locked,
  output logic              err,
  output logic              err_sticky,
  output logic [ERR_W-1:0]  err_count,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic [WIDTH-1:0]  expected
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACQUIRE = 3'd1,
    ST_CHECK   = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0]  ONE_W    = WIDTH'(1);
  localparam logic [WIDTH-1:0]  ZERO_W   = WIDTH'(0);
  localparam logic [WIDTH-1:0]  MAX_W    = {WIDTH{1'b1}};
  localparam logic [3:0]        LOCK_TGT = 4'(LOCK_N);
  localparam logic [WRAP_W-1:0] ONE_WR   = WRAP_W'(1);
  localparam logic [ERR_W-1:0]  ONE_E    = ERR_W'(1);
  localparam logic [ERR_W-1:0]  ZERO_E   = ERR_W'(0);

  // Saturating increment for the fault counter: sticks at all-ones.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (v == {ERR_W{1'b1}}) begin
      return v;
    end else begin
      return v + ONE_E;
    end
  endfunction

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    samp_q, samp_d;
  logic [WIDTH-1:0]    prev_q, prev_d;
  logic [3:0]          good_q, good_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic                sticky_q, sticky_d;
  logic [ERR_W-1:0]    errcnt_q, errcnt_d;
  logic                wrap_q, wrap_d;
  logic [WRAP_W-1:0]   wrapcnt_q, wrapcnt_d;
  logic [WIDTH-1:0]    exp_q, exp_d;

  logic [WIDTH-1:0]    prev_inc_s;
  logic                match_s;
  logic                fault_s;
  logic                wrap_s;

  // Next-state and registered-output computation for the checker FSM.
  always_comb begin
    state_d    = state_q;
    samp_d     = count_in;
    prev_d     = prev_q;
    good_d     = good_q;
    fault_s    = 1'b0;
    wrap_s     = 1'b0;
    prev_inc_s = prev_q + ONE_W;
    match_s    = (samp_q == prev_inc_s);

    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          // Take a fresh anchor; nothing is trusted yet.
          prev_d  = samp_q;
          good_d  = 4'd0;
          state_d = ST_CHECK;
        end
        ST_CHECK: begin
          prev_d = samp_q;
          if (match_s) begin
            good_d = good_q + 4'd1;
            if ((good_q + 4'd1) == LOCK_TGT) begin
              state_d = ST_LOCKED;
            end else begin
              state_d = ST_CHECK;
            end
          end else begin
            // Counter not yet trusted, so a mismatch just re-anchors.
            state_d = ST_ACQUIRE;
          end
        end
        ST_LOCKED: begin
          prev_d = samp_q;
          if (match_s) begin
            if ((prev_q == MAX_W) && (samp_q == ZERO_W)) begin
              wrap_s = 1'b1;
            end else begin
              wrap_s = 1'b0;
            end
          end else begin
            fault_s = 1'b1;
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
          state_d = ST_ACQUIRE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
    err_d    = fault_s;
    wrap_d   = wrap_s;

    // A fault in the same cycle as a clear wins over the clear.
    if (fault_s) begin
      sticky_d = 1'b1;
      if (err_clr) begin
        errcnt_d = ONE_E;
      end else begin
        errcnt_d = sat_inc(errcnt_q);
      end
    end else if (err_clr) begin
      sticky_d = 1'b0;
      errcnt_d = ZERO_E;
    end else begin
      sticky_d = sticky_q;
      errcnt_d = errcnt_q;
    end

    if (wrap_s) begin
      wrapcnt_d = wrapcnt_q + ONE_WR;
    end else begin
      wrapcnt_d = wrapcnt_q;
    end

    if (state_d == ST_IDLE) begin
      exp_d = ZERO_W;
    end else begin
      exp_d = prev_d + ONE_W;
    end
  end

  // State, sample history and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      samp_q    <= ZERO_W;
      prev_q    <= ZERO_W;
      good_q    <= 4'd0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
      errcnt_q  <= ZERO_E;
      wrap_q    <= 1'b0;
      wrapcnt_q <= WRAP_W'(0);
      exp_q     <= ZERO_W;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      prev_q    <= prev_d;
      good_q    <= good_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
      errcnt_q  <= errcnt_d;
      wrap_q    <= wrap_d;
      wrapcnt_q <= wrapcnt_d;
      exp_q     <= exp_d;
    end
  end

  assign locked     = locked_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;
  assign err_count  = errcnt_q;
  assign wrap_pulse = wrap_q;
  assign wrap_count = wrapcnt_q;
  assign expected   = exp_q;

endmodule

// File: tb/tb_up_count_checker.sv
// Bench for up_count_checker: randomized and directed counter streams
// compared every cycle against a behavioural model of the checking rules.
module tb_up_count_checker;
  localparam int WIDTH  = 4;
  localparam int LOCK_N = 2;
  localparam int WRAP_W = 8;
  localparam int ERR_W  = 4;
  localparam int MODW   = 1 << WIDTH;
  localparam int EMAX   = (1 << ERR_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [WIDTH-1:0]  count_in;
  logic              enable;
  logic              err_clr;
  logic              locked;
  logic              err;
  logic              err_sticky;
  logic [ERR_W-1:0]  err_count;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic [WIDTH-1:0]  expected;

  up_count_checker #(.WIDTH(WIDTH), .LOCK_N(LOCK_N), .WRAP_W(WRAP_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset_n(reset_n), .count_in(count_in), .enable(enable),
    .err_clr(err_clr), .locked(locked), .err(err), .err_sticky(err_sticky),
    .err_count(err_count), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
    .expected(expected)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Behavioural model: "on" (enabled), waiting for an anchor, good-run length,
  // trusted lock, one-cycle recovery after a fault.
  int m_samp, m_prev, m_streak, m_errcnt, m_wrapcnt, m_want_exp;
  bit m_on, m_anchor, m_lock, m_flt, m_err, m_wrap, m_sticky;
  int cnt;

  task automatic chk(input string tag, input int obs, input int want);
    n_cmp++;
    if (obs != want) begin
      n_mis++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic model_reset();
    m_samp = 0; m_prev = 0; m_streak = 0; m_errcnt = 0; m_wrapcnt = 0;
    m_want_exp = 0; m_on = 0; m_anchor = 0; m_lock = 0; m_flt = 0;
    m_err = 0; m_wrap = 0; m_sticky = 0;
  endtask

  task automatic model_edge();
    bit fault;
    bit good;
    fault = 0; m_err = 0; m_wrap = 0;
    if (!enable) begin
      m_on = 0; m_lock = 0; m_flt = 0; m_anchor = 0;
    end else if (!m_on) begin
      m_on = 1; m_anchor = 1;
    end else if (m_flt) begin
      m_flt = 0; m_anchor = 1;
    end else if (m_anchor) begin
      m_prev = m_samp; m_anchor = 0; m_streak = 0;
    end else begin
      good = (m_samp == (m_prev + 1) % MODW);
      if (m_lock) begin
        if (!good) begin
          fault = 1; m_lock = 0; m_flt = 1;
        end else if (m_prev == MODW - 1 && m_samp == 0) begin
          m_wrap = 1;
        end
      end else if (good) begin
        m_streak++;
        if (m_streak == LOCK_N) m_lock = 1;
      end else begin
        m_anchor = 1;
      end
      m_prev = m_samp;
    end
    if (fault) begin
      m_err = 1; m_sticky = 1;
      m_errcnt = err_clr ? 1 : ((m_errcnt == EMAX) ? EMAX : m_errcnt + 1);
    end else if (err_clr) begin
      m_sticky = 0; m_errcnt = 0;
    end
    if (m_wrap) m_wrapcnt = (m_wrapcnt + 1) % (1 << WRAP_W);
    m_want_exp = m_on ? (m_prev + 1) % MODW : 0;
    m_samp = int'(count_in);
  endtask

  task automatic check_all();
    chk("locked", int'(locked), int'(m_lock));
    chk("err", int'(err), int'(m_err));
    chk("err_sticky", int'(err_sticky), int'(m_sticky));
    chk("err_count", int'(err_count), m_errcnt);
    chk("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
    chk("wrap_count", int'(wrap_count), m_wrapcnt);
    chk("expected", int'(expected), m_want_exp);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Drive the next counter value, advancing the free-running count.
  task automatic drive_next();
    count_in = cnt[WIDTH-1:0];
    cnt = cnt + 1;
  endtask

  task automatic run_free(input int n);
    for (int i = 0; i < n; i++) begin
      drive_next();
      step();
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_sticky"}, int'(err_sticky), 0);
    chk({tag, "_errcnt"}, int'(err_count), 0);
    chk({tag, "_wrap"}, int'(wrap_pulse), 0);
    chk({tag, "_wrapcnt"}, int'(wrap_count), 0);
    chk({tag, "_expected"}, int'(expected), 0);
  endtask

  initial begin
    int lock_at, n_err, n_wrap, err_at, relock_at, locked_seen, r;
    reset_n = 1'b0; enable = 1'b0; err_clr = 1'b0; count_in = '0; cnt = 0;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Free run from 0 with enable: lock after 1+1+LOCK_N edges.
    enable = 1'b1; lock_at = 0; n_wrap = 0;
    for (int i = 1; i <= 50; i++) begin
      drive_next();
      step();
      if (locked && lock_at == 0) lock_at = i;
      if (wrap_pulse) n_wrap++;
    end
    chk("lock_latency", lock_at, 2 + LOCK_N);
    chk("wrap_pulses_3", n_wrap, 3);
    chk("wrap_count_3", int'(wrap_count), 3);

    // Skip 5 -> 7 while locked.
    while (cnt % MODW != 5) run_free(1);
    run_free(1);
    cnt = cnt + 1;
    n_err = 0; err_at = 0; relock_at = 0;
    for (int i = 1; i <= 12; i++) begin
      drive_next();
      step();
      if (err) begin n_err++; err_at = i; end
      if (err_at != 0 && locked && relock_at == 0) relock_at = i;
    end
    chk("skip_err_once", n_err, 1);
    chk("skip_errcnt", int'(err_count), 1);
    chk("skip_relock", relock_at - err_at, 2 + LOCK_N);

    // Stuck at 9 for 20 cycles: one fault only, never locked afterwards.
    while (cnt % MODW != 9) run_free(1);
    n_err = 0; locked_seen = 0;
    for (int i = 0; i < 20; i++) begin
      count_in = 4'd9;
      step();
      if (err) n_err++;
      if (i >= 3 && locked) locked_seen++;
    end
    chk("stuck_err_once", n_err, 1);
    chk("stuck_no_lock", locked_seen, 0);
    cnt = 10;
    run_free(10);

    // Saturation of the fault counter.
    for (int k = 0; k < 16; k++) begin
      run_free(10);
      cnt = cnt + 1;
    end
    run_free(10);
    chk("errcnt_saturated", int'(err_count), EMAX);

    // Clear coinciding with a fault: fault wins.
    cnt = cnt + 1;
    err_clr = 1'b1;
    drive_next(); step();
    drive_next(); step();
    err_clr = 1'b0;
    chk("clr_fault_count", int'(err_count), 1);
    chk("clr_fault_sticky", int'(err_sticky), 1);
    run_free(8);

    // Randomized stream: skips, stalls, enable toggles, clears.
    for (int i = 0; i < 1500; i++) begin
      count_in = cnt[WIDTH-1:0];
      r = $urandom_range(0, 99);
      if (r < 3) cnt = cnt + $urandom_range(2, MODW - 1);
      else if (r >= 6) cnt = cnt + 1;
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      err_clr = ($urandom_range(0, 99) < 3);
      step();
    end
    enable = 1'b1; err_clr = 1'b0;
    run_free(10);
    chk("relocked_after_random", int'(locked), 1);

    // Enable low mid-lock, then an async reset pulse between edges.
    enable = 1'b0;
    drive_next(); step();
    chk("enable_low_unlock", int'(locked), 0);
    #3 reset_n = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    #1 reset_n = 1'b1;
    enable = 1'b1;
    run_free(20);
    chk("relock_after_reset", int'(locked), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
